// File: rtl/bcd_arb_pkg.sv
// Shared types and helpers for the round-robin BCD converter scheduler.
package bcd_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        LOAD  = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam int MAX_REQ     = 16;
    localparam int NUM_REQ_DEF = 4;
    localparam int TIMEOUT_DEF = 64;
    localparam int IDW         = $clog2(NUM_REQ_DEF);
    localparam int CNTW        = $clog2(TIMEOUT_DEF + 1);

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // First set request at or after ptr, wrapping modulo num_req.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [3:0]         ptr,
                                      input int                 num_req);
        pick_t      res;
        logic [4:0] pos;
        res.found = 1'b0;
        res.idx   = 4'd0;
        for (int i = 0; i < MAX_REQ; i++) begin
            pos = {1'b0, ptr} + 5'(i);
            if (pos >= 5'(num_req)) begin
                pos = pos - 5'(num_req);
            end else begin
                pos = pos;
            end
            if ((i < num_req) && !res.found && req[pos[3:0]]) begin
                res.found = 1'b1;
                res.idx   = pos[3:0];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_conv_arbiter_rr_arbiter.sv
// Round-robin picker: combinational choice from the request vector, pointer advances on accept.
module rr_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = IDW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [ID_W-1:0]    pick_idx,
    output logic               pick_found
);

    logic [ID_W-1:0]    ptr_r;
    logic [MAX_REQ-1:0] req_ext_s;
    pick_t              pick_s;

    // Widen the request vector and search from the pointer.
    always_comb begin
        req_ext_s              = '0;
        req_ext_s[NUM_REQ-1:0] = req;
        pick_s                 = rr_pick(req_ext_s, 4'(ptr_r), NUM_REQ);
        pick_idx               = pick_s.idx[ID_W-1:0];
        pick_found             = pick_s.found;
    end

    // Pointer moves one past the accepted requester so it drops to lowest priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (accept) begin
            if (pick_idx == ID_W'(NUM_REQ - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= pick_idx + ID_W'(1);
            end
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one binary-to-BCD converter among NUM_REQ requesters, one job in flight,
// with a watchdog so a missing done strobe cannot lock the converter.
module bcd_conv_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int NUM_REQ           = NUM_REQ_DEF,
    parameter int binaryNumberWidth = 32,
    parameter int numberOfDigits    = 6,
    parameter int TIMEOUT           = TIMEOUT_DEF
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_REQ-1:0]                        req_valid,
    input  logic [NUM_REQ-1:0][binaryNumberWidth-1:0] req_binary,
    output logic [NUM_REQ-1:0]                        req_ready,
    output logic [NUM_REQ-1:0]                        resp_valid,
    output logic                                      resp_err,
    output logic [numberOfDigits*4-1:0]               resp_bcd,
    output logic                                      busy,
    output logic                                      conv_load,
    output logic [binaryNumberWidth-1:0]              conv_binary,
    input  logic [numberOfDigits*4-1:0]               conv_bcd,
    input  logic                                      conv_done
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [ID_W-1:0]  id_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             timeout_s;
    logic [ID_W-1:0]  pick_idx_s;
    logic             pick_found_s;
    logic             accept_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .clk        (clk),
        .rst        (rst),
        .req        (req_valid),
        .accept     (accept_s),
        .pick_idx   (pick_idx_s),
        .pick_found (pick_found_s)
    );

    // Acceptance strobe and watchdog compare.
    always_comb begin
        accept_s   = (state_r == IDLE) && pick_found_s;
        cnt_next_s = cnt_r + CNT_W'(1);
        timeout_s  = (cnt_next_s == CNT_W'(TIMEOUT));
    end

    // Job sequencer; every output is a register set on the edge entering the state it marks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            id_r        <= '0;
            cnt_r       <= '0;
            req_ready   <= '0;
            resp_valid  <= '0;
            resp_err    <= 1'b0;
            resp_bcd    <= '0;
            busy        <= 1'b0;
            conv_load   <= 1'b0;
            conv_binary <= '0;
        end else begin
            req_ready  <= '0;
            resp_valid <= '0;
            resp_err   <= 1'b0;
            resp_bcd   <= '0;
            conv_load  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        id_r        <= pick_idx_s;
                        conv_binary <= req_binary[pick_idx_s];
                        req_ready   <= ONE_HOT0 << pick_idx_s;
                        state_r     <= GRANT;
                        busy        <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                GRANT: begin
                    state_r <= LOAD;
                    busy    <= 1'b1;
                end
                LOAD: begin
                    conv_load <= 1'b1;
                    cnt_r     <= '0;
                    state_r   <= WAIT;
                    busy      <= 1'b1;
                end
                WAIT: begin
                    cnt_r <= cnt_next_s;
                    busy  <= 1'b1;
                    // A done strobe in the watchdog's last cycle still delivers a good result.
                    if (conv_done) begin
                        resp_valid <= ONE_HOT0 << id_r;
                        resp_err   <= 1'b0;
                        resp_bcd   <= conv_bcd;
                        state_r    <= RESP;
                    end else if (timeout_s) begin
                        resp_valid <= ONE_HOT0 << id_r;
                        resp_err   <= 1'b1;
                        resp_bcd   <= '0;
                        state_r    <= RESP;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
